// File: rtl/uart_pkg.sv
// Shared constants and timeout FSM encoding for the UART receive buffer.
package uart_pkg;

    localparam int DATA_UART     = 8;
    localparam int BITS_PER_CHAR = 10;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_COUNT = 2'd1,
        T_FIRED = 2'd2
    } tmo_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Circular register array holding its own read/write pointers.
// The read port is combinational off the registered read pointer.
module uart_fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0]  mem [2**ADDR_W];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    // Pointers wrap naturally at 2**ADDR_W.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en && !clear) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with occupancy, overrun, threshold and character-timeout flags.
//
//   state   | meaning
//   T_IDLE  | FIFO empty, timeout counters held at zero
//   T_COUNT | data waiting, counting idle bit times
//   T_FIRED | idle limit reached, timeout_irq_o held until next pop/write
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_UART     = 8,
    parameter int DEPTH_LOG2    = 4,
    parameter int DIV_SIZE      = 16,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  en_i,
    input  logic                  clear_i,
    input  logic [DIV_SIZE-1:0]   baud_div_i,
    input  logic [DATA_UART-1:0]  rx_data_i,
    input  logic                  rx_valid_i,
    input  logic                  rd_en_i,
    output logic [DATA_UART-1:0]  rd_data_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   level_o,
    input  logic [DEPTH_LOG2:0]   threshold_i,
    output logic                  thresh_irq_o,
    output logic                  overrun_o,
    input  logic                  overrun_clr_i,
    output logic                  timeout_irq_o
);

    localparam int LW        = DEPTH_LOG2 + 1;
    localparam int DEPTH     = 1 << DEPTH_LOG2;
    localparam int BIT_LIMIT = TIMEOUT_CHARS * BITS_PER_CHAR;
    localparam int BW        = $clog2(BIT_LIMIT + 1);
    localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);

    logic [LW-1:0]       level;
    logic [LW-1:0]       next_level;
    logic                wr_req;
    logic                wr_acc;
    logic                pop;
    logic                restart;
    logic [DIV_SIZE-1:0] div_eff;
    logic [DIV_SIZE-1:0] tick_cnt;
    logic [BW-1:0]       bit_cnt;
    logic                bit_tick;
    logic                char_timeout;
    tmo_state_t          tmo_state;

    assign level_o = level;
    assign empty_o = (level == '0);
    assign full_o  = (level == DEPTH_LVL);

    // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
    assign wr_req  = rx_valid_i & en_i;
    assign pop     = rd_en_i & ~empty_o;
    assign wr_acc  = wr_req & (~full_o | pop);
    assign restart = wr_acc | pop;

    always_comb begin
        next_level = level;
        if (wr_acc && !pop)
            next_level = level + 1'b1;
        else if (pop && !wr_acc)
            next_level = level - 1'b1;
    end

    uart_fifo_mem #(
        .WIDTH  (DATA_UART),
        .ADDR_W (DEPTH_LOG2)
    ) u_mem (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .clear   (clear_i),
        .wr_en   (wr_acc),
        .wr_data (rx_data_i),
        .rd_en   (pop),
        .rd_data (rd_data_o)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            level        <= '0;
            thresh_irq_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else if (clear_i) begin
            level        <= '0;
            thresh_irq_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            level        <= next_level;
            thresh_irq_o <= (threshold_i != '0) && (next_level >= threshold_i);
            if (wr_req && full_o && !pop)
                overrun_o <= 1'b1;
            else if (overrun_clr_i)
                overrun_o <= 1'b0;
        end
    end

    // A zero divisor behaves as one tick per clock.
    assign div_eff      = (baud_div_i == '0) ? DIV_SIZE'(1) : baud_div_i;
    assign bit_tick     = (tick_cnt == div_eff - DIV_SIZE'(1));
    assign char_timeout = bit_tick && (bit_cnt == BW'(BIT_LIMIT - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else if (clear_i || restart || next_level == '0) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else if (tmo_state != T_FIRED) begin
            if (bit_tick) begin
                tick_cnt <= '0;
                bit_cnt  <= bit_cnt + 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tmo_state     <= T_IDLE;
            timeout_irq_o <= 1'b0;
        end else if (clear_i) begin
            tmo_state     <= T_IDLE;
            timeout_irq_o <= 1'b0;
        end else begin
            case (tmo_state)
                T_IDLE: begin
                    timeout_irq_o <= 1'b0;
                    if (next_level != '0) tmo_state <= T_COUNT;
                end
                T_COUNT: begin
                    if (next_level == '0) begin
                        tmo_state <= T_IDLE;
                    end else if (!restart && char_timeout) begin
                        tmo_state     <= T_FIRED;
                        timeout_irq_o <= 1'b1;
                    end
                end
                T_FIRED: begin
                    if (restart) begin
                        timeout_irq_o <= 1'b0;
                        tmo_state     <= (next_level == '0) ? T_IDLE : T_COUNT;
                    end
                end
                default: begin
                    tmo_state     <= T_IDLE;
                    timeout_irq_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: stimulus queues expected bytes, a monitor checks each pop.
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        clear;
    logic [15:0] baud_div;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        empty;
    logic        full;
    logic [4:0]  level;
    logic [4:0]  threshold;
    logic        thresh_irq;
    logic        overrun;
    logic        overrun_clr;
    logic        timeout_irq;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;
    int          fired_at;

    uart_rx_fifo dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .en_i          (en),
        .clear_i       (clear),
        .baud_div_i    (baud_div),
        .rx_data_i     (rx_data),
        .rx_valid_i    (rx_valid),
        .rd_en_i       (rd_en),
        .rd_data_o     (rd_data),
        .empty_o       (empty),
        .full_o        (full),
        .level_o       (level),
        .threshold_i   (threshold),
        .thresh_irq_o  (thresh_irq),
        .overrun_o     (overrun),
        .overrun_clr_i (overrun_clr),
        .timeout_irq_o (timeout_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every real pop must deliver the oldest queued byte.
    always @(negedge clk) begin
        if (rstn && rd_en && !empty) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_data: pop with nothing expected, got 0x%0h", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("pop_data", {24'd0, rd_data}, {24'd0, mon_exp});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b, input bit kept);
        rx_valid = 1'b1;
        rx_data  = b;
        if (kept) exp_q.push_back(b);
        step();
        rx_valid = 1'b0;
    endtask

    task automatic pop_n(input int n);
        rd_en = 1'b1;
        repeat (n) step();
        rd_en = 1'b0;
    endtask

    task automatic wait_fire(input int limit);
        fired_at = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (timeout_irq && fired_at < 0) fired_at = i;
        end
    endtask

    initial begin
        rstn = 1'b0; en = 1'b1; clear = 1'b0; baud_div = 16'd10;
        rx_data = 8'h00; rx_valid = 1'b0; rd_en = 1'b0;
        threshold = 5'd0; overrun_clr = 1'b0;
        #12;
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_thresh", thresh_irq, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout_irq, 0);
        step();
        rstn = 1'b1;
        step();

        // In-order delivery, level tracking
        write_byte(8'h41, 1);
        write_byte(8'h42, 1);
        write_byte(8'h43, 1);
        check("t1_level3", level, 3);
        rd_en = 1'b1;
        step(); check("t1_level2", level, 2);
        step(); check("t1_level1", level, 1);
        step(); check("t1_level0", level, 0);
        rd_en = 1'b0;
        check("t1_empty", empty, 1);

        // Ignored operations at the edges
        en = 1'b0;
        write_byte(8'hEE, 0);
        en = 1'b1;
        check("dis_level", level, 0);
        pop_n(1);
        check("pop_empty_level", level, 0);
        rd_en = 1'b1;
        write_byte(8'h99, 1);
        rd_en = 1'b0;
        check("wr_pop_empty_level", level, 1);
        pop_n(1);

        // Fill to full, overrun on the 17th
        for (int i = 0; i < 16; i++) write_byte(8'(i), 1);
        check("t2_full", full, 1);
        check("t2_level16", level, 16);
        check("t2_no_overrun", overrun, 0);
        write_byte(8'h10, 0);
        check("t2_overrun", overrun, 1);
        check("t2_level_kept", level, 16);
        check("t2_head", rd_data, 8'h00);
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        check("t2_overrun_clr", overrun, 0);

        // Write and pop together while full
        rd_en = 1'b1;
        write_byte(8'h55, 1);
        rd_en = 1'b0;
        check("t3_level16", level, 16);
        check("t3_overrun", overrun, 0);
        pop_n(16);
        check("t3_drained", empty, 1);

        // Threshold
        threshold = 5'd4;
        write_byte(8'hA0, 1); write_byte(8'hA1, 1); write_byte(8'hA2, 1);
        check("t4_below", thresh_irq, 0);
        write_byte(8'hA3, 1);
        check("t4_reached", thresh_irq, 1);
        pop_n(1);
        check("t4_dropped", thresh_irq, 0);
        pop_n(3);
        threshold = 5'd0;

        // Character timeout, baud_div = 10 -> 400 clocks
        baud_div = 16'd10;
        write_byte(8'h77, 1);
        wait_fire(420);
        check("t5_fire_cycle", fired_at, 400);
        check("t5_held", timeout_irq, 1);
        pop_n(1);
        check("t5_cleared", timeout_irq, 0);
        check("t5_empty", empty, 1);
        repeat (60) step();
        check("t5_idle_quiet", timeout_irq, 0);

        // baud_div = 0 acts as 1 -> 40 clocks; a write re-arms the timer
        baud_div = 16'd0;
        write_byte(8'h01, 1);
        wait_fire(60);
        check("div0_fire_cycle", fired_at, 40);
        write_byte(8'h02, 1);
        check("div0_wr_clears", timeout_irq, 0);
        check("div0_level2", level, 2);
        wait_fire(60);
        check("div0_refire_cycle", fired_at, 40);
        pop_n(2);
        baud_div = 16'd10;

        // Clear beats a simultaneous write
        for (int i = 0; i < 16; i++) write_byte(8'hB0 + 8'(i), 1);
        write_byte(8'hCC, 0);
        pop_n(6);
        check("t6_level10", level, 10);
        check("t6_overrun", overrun, 1);
        clear = 1'b1;
        write_byte(8'hAA, 0);
        clear = 1'b0;
        exp_q.delete();
        check("t6_level0", level, 0);
        check("t6_empty", empty, 1);
        check("t6_overrun_clr", overrun, 0);
        write_byte(8'h12, 1);
        pop_n(1);
        check("t6_after_empty", empty, 1);

        // Asynchronous reset mid-operation
        threshold = 5'd4;
        for (int i = 0; i < 17; i++) write_byte(8'hD0 + 8'(i), i < 16);
        check("t7_pre_overrun", overrun, 1);
        check("t7_pre_thresh", thresh_irq, 1);
        #2 rstn = 1'b0;
        #1;
        exp_q.delete();
        check("t7_level", level, 0);
        check("t7_empty", empty, 1);
        check("t7_full", full, 0);
        check("t7_thresh", thresh_irq, 0);
        check("t7_overrun", overrun, 0);
        check("t7_timeout", timeout_irq, 0);
        threshold = 5'd0;
        step();
        rstn = 1'b1;
        write_byte(8'h3C, 1);
        pop_n(1);
        check("t7_final_empty", empty, 1);
        check("t7_queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer placed directly downstream of the UART RX sampler. It captures each single-cycle rx_valid/rx_data pulse into a circular FIFO and presents the oldest byte first-word-fall-through to the AXI-lite register slave. It flags overrun, fill-level threshold and character-timeout conditions for the interrupt logic. It runs in the fixed UART clock domain, beside the receiver.

Parameters:
DATA_UART, 8, width of one received character
DEPTH_LOG2, 4, log2 of FIFO depth (depth = 16)
DIV_SIZE, 16, width of the baud divisor input
TIMEOUT_CHARS, 4, idle character times before timeout fires (1 char = 10 bit times)

Ports:
clk_i  in  1  UART fixed clock
rstn_i  in  1  asynchronous active-low reset
en_i  in  1  UART enable; 0 = incoming characters dropped, no overrun set
clear_i  in  1  synchronous flush pulse
baud_div_i  in  DIV_SIZE  clocks per bit (same value fed to the receiver)
rx_data_i  in  DATA_UART  character from the receiver
rx_valid_i  in  1  one-cycle strobe, character valid
rd_en_i  in  1  pop request from the register slave
rd_data_o  out  DATA_UART  head entry (FWFT); undefined content when empty
empty_o  out  1  FIFO empty
full_o  out  1  FIFO full
level_o  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2
threshold_i  in  DEPTH_LOG2+1  level threshold; 0 disables the threshold flag
thresh_irq_o  out  1  level >= threshold (registered)
overrun_o  out  1  sticky: a character was dropped because the FIFO was full
overrun_clr_i  in  1  clears overrun_o
timeout_irq_o  out  1  sticky character-timeout flag

Behaviour:
- Reset (async, rstn_i=0): pointers = 0, level_o = 0, empty_o = 1, full_o = 0, thresh_irq_o = 0, overrun_o = 0, timeout_irq_o = 0, timeout FSM in T_IDLE, tick and bit counters = 0. Memory contents are not reset.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo the depth. Occupancy is tracked by a level counter of DEPTH_LOG2+1 bits.
- empty_o = (level==0) and full_o = (level==depth). Both are derived combinationally from the registered level.
- Write accepted when rx_valid_i & en_i & (!full_o | pop). Memory written at wr_ptr, wr_ptr+1.
- Pop = rd_en_i & !empty_o. rd_ptr+1. A rd_en_i while empty is ignored.
- Simultaneous write and pop:
  - When full: both happen, level unchanged, no overrun.
  - When empty: the write happens and the pop is ignored (level becomes 1).
- Write while full with no pop: character dropped, overrun_o set on the next edge.
- overrun_clr_i clears overrun_o. If a clear and a new overrun occur in the same cycle, set wins.
- rd_data_o = mem[rd_ptr], combinational from registered state. Latency from write to visible: 1 cycle.
- thresh_irq_o is registered: next = (threshold_i != 0) & (next_level >= threshold_i).
- Timeout tick generation:
  - Tick counter counts 0..baud_div_i-1 and produces one bit tick per wrap.
  - Bit counter counts ticks up to TIMEOUT_CHARS*10.
  - Both counters reset on any accepted write, any pop, or entry to T_IDLE.
- Timeout FSM:
  - T_IDLE: timeout_irq_o = 0. Go to T_COUNT when the FIFO is non-empty.
  - T_COUNT: go to T_IDLE if the FIFO empties. On the bit counter reaching its limit, go to T_FIRED and set timeout_irq_o.
  - T_FIRED: timeout_irq_o = 1 and held. Any pop or accepted write clears the flag and returns to T_COUNT, or to T_IDLE if the result is empty.
- clear_i (highest priority, synchronous): pointers = 0, level = 0, overrun_o = 0, thresh_irq_o = 0, timeout FSM to T_IDLE, counters = 0. A write or pop in the same cycle is discarded.
- baud_div_i = 0 is treated as 1 (one tick per clock).
- Reset asserted mid-operation returns all state to reset values immediately.

Decomposition:
- Shared package uart_pkg: DATA_UART, BITS_PER_CHAR = 10, timeout FSM state encodings (T_IDLE, T_COUNT, T_FIRED).
- One sub-module: uart_fifo_mem, a dual-pointer register array with write port and combinational read port, parameterised by width and depth.
- Control, level, flags and the timeout FSM stay in uart_rx_fifo.

Test Plan:
- Write 0x41, 0x42, 0x43 at 1-cycle spacing, then pop 3 times -> rd_data_o shows 0x41, 0x42, 0x43 in order; level_o goes 3→0; empty_o=1 after the 3rd pop.
- Write 17 chars 0x00..0x10 with no reads -> full_o=1 after the 16th; the 17th is dropped; overrun_o=1; head still 0x00. Then overrun_clr_i -> overrun_o=0.
- Fill to 16, then write 0x55 and pop in the same cycle -> level stays 16, overrun_o=0, tail entry = 0x55.
- threshold_i=4: write 4 chars -> thresh_irq_o=1 one cycle after the 4th write; pop once -> thresh_irq_o=0.
- baud_div_i=10, 1 char in FIFO, no activity -> timeout_irq_o=1 exactly 400 cycles after the write; one pop -> flag clears and FSM goes to T_IDLE.
- Partially filled FIFO with overrun set, then pulse clear_i together with rx_valid_i -> level 0, empty_o=1, overrun_o=0, incoming character discarded. Assert rstn_i mid-fill -> all outputs return to reset values asynchronously.
